// File: rtl/pacman_map_rom_if.sv
// Row-fetch port of the Pac-Man maze map store.
// PACMAN_MAP_WRITE_EN adds the wea/dina write side.
interface pacman_map_rom_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 128
);
    logic              ena;
    logic [ADDR_W-1:0] addra;
    logic [DATA_W-1:0] douta;
`ifdef PACMAN_MAP_WRITE_EN
    logic              wea;
    logic [DATA_W-1:0] dina;

    modport master (
        output ena, addra, wea, dina,
        input  douta
    );
    modport slave (
        input  ena, addra, wea, dina,
        output douta
    );
`else
    modport master (
        output ena, addra,
        input  douta
    );
    modport slave (
        input  ena, addra,
        output douta
    );
`endif
endinterface

// File: rtl/pacman_map_rom.sv
// Pac-Man maze wall map, one 128-bit row per access, 1-cycle latency.
// Define PACMAN_MAP_WRITE_EN to turn the ROM into a read-first RAM.
module pacman_map_rom #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 128,
    parameter int MAP_W  = 80
) (
    input logic              clka,
    input logic              rsta_n,
    pacman_map_rom_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int PAD_W = DATA_W - MAP_W;

    localparam logic [DATA_W-1:0] FULL_M =
        {{PAD_W{1'b0}}, {MAP_W{1'b1}}};
    localparam logic [DATA_W-1:0] SIDE_M =
        {{PAD_W{1'b0}}, 1'b1, {(MAP_W-2){1'b0}}, 1'b1};
    // 4-wide blocks at columns 3..6 of every 10-column group
    localparam logic [DATA_W-1:0] BLK_M =
        SIDE_M |
        {{PAD_W{1'b0}}, {(MAP_W/10){10'b0001111000}}};

    function automatic logic [DATA_W-1:0] map_row(input int r);
        logic [DATA_W-1:0] v;
        if (r == 0 || r == DEPTH-1) begin
            v = FULL_M;
        end else if (r >= 4 && r <= DEPTH-5 &&
                     (r % 8 == 4 || r % 8 == 5)) begin
            v = BLK_M;
        end else begin
            v = SIDE_M;
        end
        return v;
    endfunction

    function automatic logic [DEPTH-1:0][DATA_W-1:0] init_map();
        logic [DEPTH-1:0][DATA_W-1:0] m;
        for (int r = 0; r < DEPTH; r++) begin
            m[r] = map_row(r);
        end
        return m;
    endfunction

    localparam logic [DEPTH-1:0][DATA_W-1:0] MAP = init_map();

`ifdef PACMAN_MAP_WRITE_EN
    localparam logic [DATA_W-1:0] KEEP_M = FULL_M;

    logic [DEPTH-1:0][DATA_W-1:0] mem = MAP;

    always_ff @(posedge clka) begin
        if (rsta_n && bus.ena && bus.wea) begin
            mem[bus.addra] <= bus.dina & KEEP_M;
        end
    end

    // read-first: the old row is sampled in the same edge as the write
    always_ff @(posedge clka) begin
        if (!rsta_n) begin
            bus.douta <= '0;
        end else if (bus.ena) begin
            bus.douta <= mem[bus.addra];
        end
    end
`else
    always_ff @(posedge clka) begin
        if (!rsta_n) begin
            bus.douta <= '0;
        end else if (bus.ena) begin
            bus.douta <= MAP[bus.addra];
        end
    end
`endif

endmodule

// File: tb/tb_pacman_map_rom.sv
// Directed plus randomized checks of pacman_map_rom against a
// cell-by-cell model of the maze rules.
module tb_pacman_map_rom;
    logic clka = 1'b0;
    logic rsta_n;

    int total = 0;
    int bad   = 0;

    localparam logic [127:0] FULL =
        128'h0000_0000_0000_FFFF_FFFF_FFFF_FFFF_FFFF;
    localparam logic [127:0] SIDE =
        (128'h1 << 79) | 128'h1;

    logic [127:0] model [64];
    logic [127:0] held;

    pacman_map_rom_if bus ();

    pacman_map_rom dut (
        .clka   (clka),
        .rsta_n (rsta_n),
        .bus    (bus)
    );

    always #5 clka = ~clka;

    function automatic logic [127:0] exp_row(input int r);
        logic [127:0] v;
        v = '0;
        for (int c = 0; c < 80; c++) begin
            if (r == 0 || r == 63 || c == 0 || c == 79)
                v[c] = 1'b1;
            else if (r >= 4 && r <= 59 &&
                     (r % 8 == 4 || r % 8 == 5) &&
                     c >= 3 && c <= 76 &&
                     c % 10 >= 3 && c % 10 <= 6)
                v[c] = 1'b1;
        end
        return v;
    endfunction

    task automatic chk(input string tag,
                       input logic [127:0] got,
                       input logic [127:0] exp);
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // one clock edge, with the model advanced the same way
    task automatic tick();
        logic [5:0] a;
        logic       en;
        logic       rn;
`ifdef PACMAN_MAP_WRITE_EN
        logic         we;
        logic [127:0] di;
        we = bus.wea;
        di = bus.dina;
`endif
        a  = bus.addra;
        en = bus.ena;
        rn = rsta_n;
        @(posedge clka);
        if (!rn) begin
            held = '0;
        end else if (en) begin
            held = model[a];
`ifdef PACMAN_MAP_WRITE_EN
            if (we) model[a] = di & FULL;
`endif
        end
        #1;
    endtask

    initial begin
        for (int r = 0; r < 64; r++) model[r] = exp_row(r);
        held = '0;
`ifdef PACMAN_MAP_WRITE_EN
        bus.wea  = 1'b0;
        bus.dina = '0;
`endif

        rsta_n    = 1'b0;
        bus.ena   = 1'b1;
        bus.addra = 6'd5;
        tick();
        tick();
        chk("reset", bus.douta, 128'h0);
        rsta_n = 1'b1;
        tick();
        chk("row5_after_reset", bus.douta, held);

        bus.addra = 6'd0;
        tick();
        chk("row0", bus.douta, FULL);
        bus.addra = 6'd63;
        tick();
        chk("row63", bus.douta, FULL);

        bus.addra = 6'd1;
        tick();
        chk("row1", bus.douta, SIDE);
        chk("row1_pad", {80'h0, bus.douta[127:80]}, 128'h0);
        bus.addra = 6'd4;
        tick();
        chk("row4", bus.douta, exp_row(4));
        chk("row4_pad", {80'h0, bus.douta[127:80]}, 128'h0);
        bus.addra = 6'd60;
        tick();
        chk("row60", bus.douta, SIDE);
        chk("row60_pad", {80'h0, bus.douta[127:80]}, 128'h0);

        bus.addra = 6'd0;
        tick();
        chk("hold_pre", bus.douta, FULL);
        bus.ena   = 1'b0;
        bus.addra = 6'd1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("hold_%0d", i), bus.douta, FULL);
        end
        bus.ena = 1'b1;
        tick();
        chk("hold_release", bus.douta, SIDE);

        for (int r = 0; r < 64; r++) begin
            bus.addra = 6'(r);
            tick();
            chk($sformatf("sweep_%0d", r), bus.douta, exp_row(r));
        end

        for (int i = 0; i < 60; i++) begin
            bus.addra = 6'($urandom_range(0, 63));
            bus.ena   = ($urandom_range(0, 3) != 0);
            rsta_n    = ($urandom_range(0, 7) != 0);
            tick();
            chk($sformatf("rand_%0d", i), bus.douta, held);
        end
        rsta_n  = 1'b1;
        bus.ena = 1'b1;

`ifdef PACMAN_MAP_WRITE_EN
        bus.addra = 6'd10;
        bus.dina  = '1;
        bus.wea   = 1'b1;
        tick();
        chk("wr_read_first", bus.douta, exp_row(10));
        bus.wea = 1'b0;
        tick();
        chk("wr_readback", bus.douta, FULL);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
